// File: rtl/audio_in_level_detector.sv
// audio_in_level_detector: drains stereo audio FIFO into a mono stream, tracks a peak/decay envelope
// and runs a hysteretic note-on/note-off detector driving note_active/onset.
module audio_in_level_detector #(
  parameter int          DECAY_SHIFT  = 6,
  parameter logic [15:0] ON_THRESH    = 16'd4096,
  parameter logic [15:0] OFF_THRESH   = 16'd1024,
  parameter logic [15:0] HOLD_SAMPLES = 16'd480
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        audio_in_available,
  input  logic [31:0] left_channel_audio_in,
  input  logic [31:0] right_channel_audio_in,
  output logic        read_audio_in,
  output logic [15:0] sample_mono,
  output logic        sample_valid,
  output logic [15:0] level,
  output logic        note_active,
  output logic        onset,
  output logic [15:0] sample_count
);
  typedef enum logic [1:0] {WAIT, READ, GAP} rd_t;
  typedef enum logic {SILENT, SOUNDING} nt_t;
  rd_t rd, rd_n;
  nt_t nt, nt_n;
  logic [15:0] left_s, right_s, mono, mono_mag, mag, dec, env_n, hold, hold_n;
  logic [16:0] sum;
  logic        onset_n, unused_bits;
  assign unused_bits = ^{left_channel_audio_in[15:0], right_channel_audio_in[15:0]};
  assign sum = {left_s[15], left_s} + {right_s[15], right_s};
  assign mono = sum[16:1];
  assign mono_mag = (mono == 16'h8000) ? 16'h7fff : mono[15] ? -mono : mono;
  // a zero shift term would stall the decay above 0, so fall back to stepping by 1
  assign dec = level >> DECAY_SHIFT;
  assign env_n = (mag > level) ? mag : level - ((dec == 16'd0 && level != 16'd0) ? 16'd1 : dec);
  assign note_active = (nt == SOUNDING);
  always_comb begin
    rd_n = rd;
    case (rd)
      WAIT:    rd_n = audio_in_available ? READ : WAIT;
      READ:    rd_n = GAP;
      default: rd_n = WAIT;
    endcase
  end
  always_comb begin
    nt_n = nt;
    hold_n = hold;
    onset_n = 1'b0;
    if (rd == GAP) begin
      if (nt == SILENT) begin
        if (env_n >= ON_THRESH) begin
          nt_n = SOUNDING;
          onset_n = 1'b1;
          hold_n = 16'd0;
        end
      end else if (env_n < OFF_THRESH) begin
        if (hold == HOLD_SAMPLES - 16'd1) begin
          nt_n = SILENT;
          hold_n = 16'd0;
        end else if (hold != 16'hffff) begin
          hold_n = hold + 16'd1;
        end
      end else begin
        hold_n = 16'd0;
      end
    end
  end
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      rd <= WAIT;
      nt <= SILENT;
      hold <= '0;
      left_s <= '0;
      right_s <= '0;
      mag <= '0;
      read_audio_in <= 1'b0;
      sample_mono <= '0;
      sample_valid <= 1'b0;
      level <= '0;
      onset <= 1'b0;
      sample_count <= '0;
    end else begin
      rd <= rd_n;
      nt <= nt_n;
      hold <= hold_n;
      onset <= onset_n;
      read_audio_in <= (rd_n == READ);
      sample_valid <= (rd == READ);
      if (rd == WAIT && audio_in_available) begin
        left_s <= left_channel_audio_in[31:16];
        right_s <= right_channel_audio_in[31:16];
      end
      if (rd == READ) begin
        sample_mono <= mono;
        mag <= mono_mag;
        sample_count <= sample_count + 16'd1;
      end
      if (rd == GAP) level <= env_n;
    end
  end
endmodule

// File: tb/tb_audio_in_level_detector.sv
// tb_audio_in_level_detector: randomized and directed scenarios checked against an arithmetic reference model.
module tb_audio_in_level_detector;
  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        avail = 1'b0;
  logic [31:0] lin = '0, rin = '0;
  logic        read_audio_in, sample_valid, note_active, onset;
  logic [15:0] sample_mono, level, sample_count;
  int checks = 0, errors = 0;
  int m_env, m_quiet, m_cnt;
  bit m_note, m_onset;

  audio_in_level_detector dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .audio_in_available(avail),
    .left_channel_audio_in(lin), .right_channel_audio_in(rin),
    .read_audio_in(read_audio_in), .sample_mono(sample_mono), .sample_valid(sample_valid),
    .level(level), .note_active(note_active), .onset(onset), .sample_count(sample_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic void model_reset();
    m_env = 0; m_quiet = 0; m_cnt = 0; m_note = 0; m_onset = 0;
  endfunction

  // {handshake_ok, mono, envelope, note, onset}
  function automatic logic [34:0] model_step(input logic [31:0] l, input logic [31:0] r);
    int a, b, mono, mag, d;
    a = $signed(l[31:16]);
    b = $signed(r[31:16]);
    mono = (a + b) >>> 1;
    mag = (mono < 0) ? -mono : mono;
    if (mag > 32767) mag = 32767;
    d = m_env / 64;
    if (mag > m_env) m_env = mag;
    else m_env -= (d > 0) ? d : ((m_env > 0) ? 1 : 0);
    m_onset = 0;
    if (!m_note) begin
      if (m_env >= 4096) begin m_note = 1; m_onset = 1; m_quiet = 0; end
    end else if (m_env < 1024) begin
      m_quiet++;
      if (m_quiet == 480) begin m_note = 0; m_quiet = 0; end
    end else m_quiet = 0;
    m_cnt = (m_cnt + 1) % 65536;
    return {1'b1, 16'(mono), 16'(m_env), m_note, m_onset};
  endfunction

  function automatic logic [31:0] rnd_word();
    logic [15:0] v;
    logic signed [15:0] s;
    v = 16'($urandom());
    s = $signed(v) >>> $urandom_range(0, 15);
    return {s, 16'($urandom())};
  endfunction

  // One handshake; returns at t0+3 (+1) with observed and model-predicted outputs.
  task automatic send(input logic [31:0] l, input logic [31:0] r, output logic [34:0] got, output logic [34:0] exp);
    int n = 0;
    logic hs = 1'b1;
    logic [15:0] mono;
    lin = l; rin = r; avail = 1'b1;
    do begin @(posedge CLOCK_50); #1; n++; end while (!read_audio_in && n < 8);
    if (!read_audio_in) hs = 1'b0;
    avail = 1'b0;
    @(posedge CLOCK_50); #1;
    mono = sample_mono;
    if (!sample_valid || read_audio_in) hs = 1'b0;
    @(posedge CLOCK_50); #1;
    if (sample_valid || read_audio_in) hs = 1'b0;
    got = {hs, mono, level, note_active, onset};
    exp = model_step(l, r);
  endtask

  task automatic test_reset();
    reset = 1'b1; avail = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    checks++;
    if ({read_audio_in, sample_mono, sample_valid, level, note_active, onset, sample_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", {read_audio_in, sample_mono, sample_valid, level, note_active, onset, sample_count});
    end
    @(negedge CLOCK_50) reset = 1'b0;
    model_reset();
    @(posedge CLOCK_50); #1;
  endtask

  task automatic test_single();
    logic [34:0] got, exp;
    send(32'h4000_0000, 32'h2000_0000, got, exp);
    checks++;
    if (got[34:2] !== {1'b1, 16'h3000, 16'h3000}) begin
      errors++; $display("FAIL single_sample got %h exp %h", got[34:2], {1'b1, 16'h3000, 16'h3000});
    end
    checks++;
    if (got !== exp) begin errors++; $display("FAIL single_model got %h exp %h", got, exp); end
    checks++;
    if (sample_count !== 16'd1) begin errors++; $display("FAIL single_count got %0d exp 1", sample_count); end
  endtask

  task automatic test_saturation();
    logic [34:0] got, exp;
    send(32'h8000_0000, 32'h8000_0000, got, exp);
    checks++;
    if (got[34:2] !== {1'b1, 16'h8000, 16'd32767}) begin
      errors++; $display("FAIL saturation got %h exp %h", got[34:2], {1'b1, 16'h8000, 16'd32767});
    end
    checks++;
    if (got !== exp) begin errors++; $display("FAIL saturation_model got %h exp %h", got, exp); end
  endtask

  task automatic test_decay();
    logic [34:0] got, exp;
    logic [15:0] prev;
    int n = 0;
    while (m_env != 0 && n < 1000) begin
      send('0, '0, got, exp);
      n++;
      checks++;
      if (got !== exp) begin errors++; $display("FAIL decay_drain[%0d] got %h exp %h", n, got, exp); end
    end
    send(32'h2000_0000, 32'h2000_0000, got, exp);
    checks++;
    if (got[17:2] !== 16'd8192) begin errors++; $display("FAIL decay_peak got %0d exp 8192", got[17:2]); end
    send('0, '0, got, exp);
    checks++;
    if (got[17:2] !== 16'd8064) begin errors++; $display("FAIL decay_second got %0d exp 8064", got[17:2]); end
    prev = got[17:2];
    n = 0;
    while (prev != 16'd0 && n < 1000) begin
      send('0, '0, got, exp);
      n++;
      checks++;
      if (got !== exp || got[17:2] > prev) begin
        errors++; $display("FAIL decay_step[%0d] got %h exp %h prev %0d", n, got, exp, prev);
      end
      prev = got[17:2];
    end
    checks++;
    if (prev !== 16'd0) begin errors++; $display("FAIL decay_zero got %0d exp 0", prev); end
  endtask

  task automatic test_onset_hysteresis();
    logic [34:0] got, exp;
    int n = 0, k = 0;
    while (m_note && n < 1000) begin
      send('0, '0, got, exp);
      n++;
      checks++;
      if (got !== exp) begin errors++; $display("FAIL onset_settle[%0d] got %h exp %h", n, got, exp); end
    end
    send({16'd5000, 16'h0}, {16'd5000, 16'h0}, got, exp);
    checks++;
    if (got[1:0] !== 2'b11 || got !== exp) begin errors++; $display("FAIL onset_burst got %h exp %h", got, exp); end
    @(posedge CLOCK_50); #1;
    checks++;
    if (onset !== 1'b0) begin errors++; $display("FAIL onset_width got %b exp 0", onset); end
    for (int i = 0; i < 5; i++) begin
      send({16'd2000, 16'h0}, {16'd2000, 16'h0}, got, exp);
      checks++;
      if (got[1] !== 1'b1 || got !== exp) begin errors++; $display("FAIL onset_mid[%0d] got %h exp %h", i, got, exp); end
    end
    n = 0;
    while (k < 200 && n < 1000) begin
      send('0, '0, got, exp);
      n++;
      k = (got[17:2] < 16'd1024) ? k + 1 : 0;
      checks++;
      if (got[1] !== 1'b1 || got !== exp) begin errors++; $display("FAIL onset_quiet[%0d] got %h exp %h", n, got, exp); end
    end
    send({16'd2000, 16'h0}, {16'd2000, 16'h0}, got, exp);
    checks++;
    if (got[1] !== 1'b1 || got !== exp) begin errors++; $display("FAIL onset_restart got %h exp %h", got, exp); end
    k = 0; n = 0;
    do begin
      send('0, '0, got, exp);
      n++;
      k = (got[17:2] < 16'd1024) ? k + 1 : 0;
      checks++;
      if (got !== exp) begin errors++; $display("FAIL onset_release[%0d] got %h exp %h", n, got, exp); end
    end while (got[1] && n < 2000);
    checks++;
    if (k != 480 || got[1] !== 1'b0) begin errors++; $display("FAIL release_count got %0d exp 480", k); end
  endtask

  task automatic test_random();
    logic [34:0] got, exp;
    for (int i = 0; i < 300; i++) begin
      send(($urandom_range(0, 3) == 0) ? 32'h0 : rnd_word(), rnd_word(), got, exp);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL random[%0d] got %h exp %h", i, got, exp); end
    end
    checks++;
    if (sample_count !== 16'(m_cnt)) begin errors++; $display("FAIL random_count got %0d exp %0d", sample_count, m_cnt); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0, last = 0;
    bit bad = 0;
    logic [15:0] c0;
    c0 = sample_count;
    lin = '0; rin = '0; avail = 1'b1;
    for (int i = 1; i <= 1000; i++) begin
      @(posedge CLOCK_50); #1;
      if (read_audio_in) begin
        if (pulses > 0 && i - last != 3) bad = 1;
        pulses++;
        last = i;
      end
    end
    avail = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    checks++;
    if (bad || pulses < 333 || pulses > 334) begin errors++; $display("FAIL b2b_pulses got %0d spacing_bad %0d exp 333..334", pulses, bad); end
    checks++;
    if (16'(sample_count - c0) !== 16'(pulses)) begin
      errors++; $display("FAIL b2b_count got %0d exp %0d", 16'(sample_count - c0), pulses);
    end
  endtask

  task automatic test_reset_mid();
    logic [34:0] got, exp;
    int n = 0;
    lin = 32'h1234_0000; rin = 32'h1234_0000; avail = 1'b1;
    do begin @(posedge CLOCK_50); #1; n++; end while (!read_audio_in && n < 8);
    checks++;
    if (read_audio_in !== 1'b1) begin errors++; $display("FAIL midreset_read got %b exp 1", read_audio_in); end
    reset = 1'b1;
    #1;
    checks++;
    if ({read_audio_in, sample_mono, sample_valid, level, note_active, onset, sample_count} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got %h exp 0", {read_audio_in, sample_mono, sample_valid, level, note_active, onset, sample_count});
    end
    avail = 1'b0;
    @(negedge CLOCK_50) reset = 1'b0;
    model_reset();
    @(posedge CLOCK_50); #1;
    send(32'h1800_0000, 32'h0800_0000, got, exp);
    checks++;
    if (got !== exp || sample_count !== 16'd1) begin
      errors++; $display("FAIL midreset_resume got %h cnt %0d exp %h cnt 1", got, sample_count, exp);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_saturation();
    test_decay();
    test_onset_hysteresis();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
